// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the pipeline MEM stage and the debug/loader port.
// Fixed pipeline priority, with a starvation counter that forces a debug grant after STARVE_MAX waiting cycles.
module dmem_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pipe_req,
  input  logic          pipe_we,
  input  logic [AW-1:0] pipe_addr,
  input  logic [DW-1:0] pipe_wdata,
  output logic [DW-1:0] pipe_rdata,
  output logic          pipe_stall,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_ack,
  output logic [DW-1:0] dbg_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int LW = $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t        state_q;
  logic          owner_q;  // 1 = debug port owns the current transaction
  logic          cmd_we_q;
  logic [SW-1:0] starve_q, starve_d;
  logic [LW-1:0] wait_q;
  logic [DW-1:0] pipe_rdata_q, dbg_rdata_q;
  logic          mem_en_q, mem_we_q, dbg_ack_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;

  logic          starve_hit, grant_dbg, grant_pipe;
  logic          win_we;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;

  always_comb begin
    starve_hit = (starve_q >= SW'(STARVE_MAX));
    grant_dbg  = (state_q == S_IDLE) && dbg_req && (starve_hit || !pipe_req);
    grant_pipe = (state_q == S_IDLE) && pipe_req && !grant_dbg;
    win_we     = grant_dbg ? dbg_we    : pipe_we;
    win_addr   = grant_dbg ? dbg_addr  : pipe_addr;
    win_wdata  = grant_dbg ? dbg_wdata : pipe_wdata;
  end

  // Waiting is counted in every state, not only IDLE, so long pipeline bursts still age the debug request.
  always_comb begin
    starve_d = starve_q;
    if (grant_dbg) begin
      starve_d = '0;
    end else if (dbg_req && !starve_hit) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      cmd_we_q     <= 1'b0;
      starve_q     <= '0;
      wait_q       <= '0;
      pipe_rdata_q <= '0;
      dbg_rdata_q  <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      dbg_ack_q    <= 1'b0;
    end else begin
      starve_q  <= starve_d;
      mem_en_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      dbg_ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant_dbg || grant_pipe) begin
            owner_q     <= grant_dbg;
            cmd_we_q    <= win_we;
            mem_addr_q  <= win_addr;
            mem_wdata_q <= win_wdata;
            mem_en_q    <= 1'b1;
            mem_we_q    <= win_we;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (cmd_we_q) begin
            dbg_ack_q <= owner_q;
            state_q   <= S_DONE;
          end else begin
            wait_q  <= LW'(RD_LAT);
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          wait_q <= wait_q - LW'(1);
          if (wait_q == LW'(1)) begin
            if (owner_q) begin
              dbg_rdata_q <= mem_rdata;
            end else begin
              pipe_rdata_q <= mem_rdata;
            end
            dbg_ack_q <= owner_q;
            state_q   <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign pipe_stall = pipe_req && !((state_q == S_DONE) && !owner_q);
  assign pipe_rdata = pipe_rdata_q;
  assign dbg_rdata  = dbg_rdata_q;
  assign dbg_ack    = dbg_ack_q;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule
